gyro_debug_snapshot: RTL

Downstream consumer of the gyro channel debug counters. Takes the free-running, strobe-clocked 32-bit debug words, brings them into the `clock` domain, and captures a stable snapshot on request. It computes per-lane deltas against the previous accepted snapshot and presents the result over a valid/ready handshake. It also drives the counters' `debug_clear` as a stretched pulse.

---
 rtl/gyro_debug_snapshot_if.sv | 40 ++++
 rtl/gyro_debug_snapshot.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/gyro_debug_snapshot_if.sv
// gyro_debug_snapshot_if
// Request / snapshot bundle between the snapshot block and its consumer.
//   master : consumer side - drives snap_req, clear_req, snap_ready and
//            observes the snapshot fields and status.
//   slave  : snapshot block side - the inverse.
// Signals:
//   snap_req, clear_req  one-cycle requests
//   snap_ready           consumer accepts the snapshot
//   snap_valid           snapshot fields are valid (frozen while high)
//   snap_word_0/1        captured debug words
//   snap_delta           per-byte (capture - baseline) mod 256
//   snap_unstable        capture forced by settle timeout
//   snap_count           accepted snapshots, wrapping
//   overrun              sticky dropped-request flag
//   busy                 block not idle
interface gyro_debug_snapshot_if;
  logic        snap_req;
  logic        clear_req;
  logic        snap_ready;
  logic        snap_valid;
  logic [31:0] snap_word_0;
  logic [31:0] snap_word_1;
  logic [31:0] snap_delta;
  logic        snap_unstable;
  logic [15:0] snap_count;
  logic        overrun;
  logic        busy;

  modport master (
    output snap_req, clear_req, snap_ready,
    input  snap_valid, snap_word_0, snap_word_1, snap_delta,
           snap_unstable, snap_count, overrun, busy
  );

  modport slave (
    input  snap_req, clear_req, snap_ready,
    output snap_valid, snap_word_0, snap_word_1, snap_delta,
           snap_unstable, snap_count, overrun, busy
  );
endinterface

// File: rtl/gyro_debug_snapshot.sv
// gyro_debug_snapshot
// Brings the free-running gyro debug words into the clock domain, takes a
// stable snapshot on request, computes per-lane deltas against the last
// accepted snapshot and offers it on a valid/ready handshake. Also drives
// a stretched debug_clear pulse to the counters.
// Ports:
//   clock, reset       single clock, asynchronous active-high reset
//   debug_word_0/1     asynchronous debug words (word 0 = four 8-bit lanes)
//   debug_clear        counter clear pulse, CLEAR_CYCLES wide
//   snap               request/snapshot bundle (slave side)
module gyro_debug_snapshot #(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CLEAR_CYCLES   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [31:0]                 debug_word_0,
  input  logic [31:0]                 debug_word_1,
  output logic                        debug_clear,
  gyro_debug_snapshot_if.slave        snap
);

  localparam logic [3:0] MATCH_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] CLR_LAST   = 4'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [63:0] sync1_q, sync2_q, prev_q;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  clr_cnt_q, clr_cnt_d;
  logic [31:0] base_q, base_d;
  logic [31:0] word0_q, word0_d;
  logic [31:0] word1_q, word1_d;
  logic [31:0] delta_q, delta_d;
  logic        unstable_q, unstable_d;
  logic [15:0] count_q, count_d;
  logic        overrun_q, overrun_d;
  logic        valid_q, clear_q, busy_q;
  logic        samples_equal;

  // Per-lane modular difference; a wrapped lane still yields the small delta.
  function automatic logic [31:0] lane_delta(input logic [31:0] cur,
                                             input logic [31:0] base_w);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      d[8*k +: 8] = cur[8*k +: 8] - base_w[8*k +: 8];
    end
    return d;
  endfunction

  // Synchronizer stage: two flops plus one-deep history for stability test
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {debug_word_1, debug_word_0};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign samples_equal = (sync2_q == prev_q);

  // Control / capture next-state
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    timer_d     = timer_q;
    clr_cnt_d   = clr_cnt_q;
    base_d      = base_q;
    word0_d     = word0_q;
    word1_d     = word1_q;
    delta_d     = delta_q;
    unstable_d  = unstable_q;
    count_d     = count_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (snap.clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          base_d    = '0;
          // Clearing overrun on entry, but a simultaneous snap_req is a
          // dropped request in its own right and re-arms it.
          overrun_d = snap.snap_req;
        end else if (snap.snap_req) begin
          state_d     = SETTLE;
          match_cnt_d = '0;
          timer_d     = '0;
        end
      end
      SETTLE: begin
        match_cnt_d = samples_equal ? match_cnt_q + 4'd1 : '0;
        timer_d     = timer_q + 8'd1;
        if ((samples_equal && (match_cnt_q == MATCH_LAST)) ||
            (timer_q == TIMER_LAST)) begin
          state_d    = HOLD;
          word0_d    = sync2_q[31:0];
          word1_d    = sync2_q[63:32];
          delta_d    = lane_delta(sync2_q[31:0], base_q);
          unstable_d = !(samples_equal && (match_cnt_q == MATCH_LAST));
        end
      end
      HOLD: begin
        if (snap.snap_ready) begin
          state_d = IDLE;
          base_d  = word0_q;
          count_d = count_q + 16'd1;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (snap.snap_req || snap.clear_req)) begin
      overrun_d = 1'b1;
    end
  end

  // State / output register stage: status flags follow the next state so
  // they line up with it and drop asynchronously on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      match_cnt_q <= '0;
      timer_q     <= '0;
      clr_cnt_q   <= '0;
      base_q      <= '0;
      word0_q     <= '0;
      word1_q     <= '0;
      delta_q     <= '0;
      unstable_q  <= 1'b0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      valid_q     <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      timer_q     <= timer_d;
      clr_cnt_q   <= clr_cnt_d;
      base_q      <= base_d;
      word0_q     <= word0_d;
      word1_q     <= word1_d;
      delta_q     <= delta_d;
      unstable_q  <= unstable_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      valid_q     <= (state_d == HOLD);
      clear_q     <= (state_d == CLEAR);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign debug_clear        = clear_q;
  assign snap.snap_valid    = valid_q;
  assign snap.snap_word_0   = word0_q;
  assign snap.snap_word_1   = word1_q;
  assign snap.snap_delta    = delta_q;
  assign snap.snap_unstable = unstable_q;
  assign snap.snap_count    = count_q;
  assign snap.overrun       = overrun_q;
  assign snap.busy          = busy_q;

endmodule
